src_operand_collector: RTL and testbench
========================================

Name: src_operand_collector

Overview:
- Parametrised, sequential successor to the single-operand combinational source mux.
- Accepts one issue request carrying up to NUM_SRC operand selects and captures scalar, constant and exec-unit values at accept.
- Gathers VGPR operands that return later, possibly out of order, and presents all operands together with a valid/ready handshake.
- Sits between issue/decode and the ALU (SIMD/SIMF) operand inputs.

Parameters:
- NUM_SRC, 3, operand slots per request (1..4).
- NUM_LANES, 64, lanes per wavefront.
- DATA_W, 32, bits per lane word (>=32).
- SEL_W, 4, width of one select code.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request valid.
- req_ready  out  1  request can be accepted.
- req_sel  in  NUM_SRC*SEL_W  per-slot select. Slot i is at [i*SEL_W +: SEL_W].
- req_src_constant  in  NUM_SRC*10  per-slot inline constant.
- req_literal  in  32  literal shared by all slots.
- req_sgpr_data  in  NUM_SRC*32  per-slot SGPR read data.
- req_exec  in  64  exec mask.
- req_vcc  in  64  VCC value.
- req_m0  in  32  M0 value.
- req_scc  in  1  SCC value.
- vgpr_rd_valid  in  1  one VGPR operand beat returning.
- vgpr_rd_slot  in  2  slot index of the returning beat.
- vgpr_rd_data  in  NUM_LANES*DATA_W  VGPR beat data.
- out_valid  out  1  all operands collected.
- out_ready  in  1  consumer accepts.
- out_data  out  NUM_SRC*NUM_LANES*DATA_W  collected operands. Slot i is at [i*NUM_LANES*DATA_W +: NUM_LANES*DATA_W].
- out_err  out  1  sticky-per-request error flag.

Behaviour:
- Reset (rst low, asynchronous): state IDLE; req_ready=1; out_valid=0; out_err=0; out_data=0; pending mask=0.
- States:
  - IDLE: req_ready=1.
  - COLLECT: req_ready=0; waiting on VGPR beats.
  - OUT: out_valid=1; req_ready=out_ready.
- Accept occurs when req_valid && req_ready. Per slot, on accept:
  - sel 0010 (VGPR): set pending[i].
  - Any other sel: register the broadcast value into the slot (every lane identical).
- Select encoding:
  - 0000: literal.
  - 0001: constant sign-extended from bit 9.
  - 0011: SGPR.
  - 0100 / 0101: VCC low / high word.
  - 0110: M0.
  - 0111 / 1000: EXEC low / high word.
  - 1001: {0, !(&vcc)}.
  - 1010: {0, !(&exec)}.
  - 1011: {0, scc}.
  - 32-bit values are zero-extended to DATA_W; the constant is sign-extended to DATA_W.
  - Codes 1100–1111: slot is zeroed and out_err is set. Never drive X.
- Transitions:
  - Accept with pending!=0 goes to COLLECT.
  - Accept with pending==0 goes to OUT.
  - Latency in that case: out_valid rises 1 cycle after accept.
- In COLLECT, a vgpr_rd_valid beat with pending[slot]=1 writes the slot and clears pending[slot].
  - When the last pending bit clears, go to OUT the next cycle.
  - Latency: out_valid rises 1 cycle after the last beat.
- Erroneous beats:
  - A beat in IDLE or OUT, for a non-pending slot, or with slot>=NUM_SRC is discarded.
  - In COLLECT or OUT such a beat sets out_err for the current request; in IDLE it is dropped silently.
- Output handshake:
  - out_data and out_err are held stable while out_valid && !out_ready.
  - On out_valid && out_ready: if req_valid in the same cycle, accept back-to-back (zero bubble). Otherwise return to IDLE.
  - out_err is cleared at each accept.
- Reset mid-COLLECT or mid-OUT discards the request entirely; no partial output appears after reset release.

Optional Feature:
- Macro: SRC_EXEC_MASK_EN.
- Defined: at OUT entry, lanes with the captured exec bit = 0 are forced to zero in every slot, including broadcast slots.
- Undefined: lanes pass unmasked.

Decomposition:
- Shared package holds:
  - Select-code constants (SRC_SEL_LITERAL … SRC_SEL_SCC).
  - SRC_SEL_VGPR.
  - A 2-bit collector state typedef (IDLE/COLLECT/OUT).
- Natural sub-module: src_scalar_decode. Combinational, one instance per slot. Maps sel plus captured scalar inputs to a DATA_W word and an illegal flag.

Test Plan:
- Scalar-only request, sel={0000,0001,0011}, literal=0xDEADBEEF, const=10'h3FF, sgpr=0x12 → out_valid 1 cycle after accept. Every lane of slot0=0xDEADBEEF, slot1=0xFFFFFFFF, slot2=0x12; out_err=0.
- Two VGPR slots; beats return slot2 then slot0, 3 cycles apart → out_valid exactly 1 cycle after the slot0 beat, with both slots correct and slot1 scalar intact.
- out_ready held low 5 cycles with out_valid=1 → out_data stable; req_ready=0; new req_valid not accepted. Raising out_ready together with req_valid accepts the new request in that cycle.
- sel=1101 on slot1 → slot1 all zero, out_err=1. A duplicate beat for an already-filled slot also sets out_err without corrupting the data.
- rst asserted mid-COLLECT → immediate out_valid=0 and req_ready=1 after release; a late beat for the old request is ignored.
- With SRC_EXEC_MASK_EN, exec=64'h00000000_0000FFFF → lanes 16–63 zero in all slots. Without the macro, those lanes are unmasked.

Source files
------------

// File: rtl/src_operand_collector_pkg.sv
// Shared select codes and collector state encoding for the source operand collector.
package src_operand_collector_pkg;

   localparam logic [3:0] SRC_SEL_LITERAL = 4'b0000;
   localparam logic [3:0] SRC_SEL_CONST   = 4'b0001;
   localparam logic [3:0] SRC_SEL_VGPR    = 4'b0010;
   localparam logic [3:0] SRC_SEL_SGPR    = 4'b0011;
   localparam logic [3:0] SRC_SEL_VCC_LO  = 4'b0100;
   localparam logic [3:0] SRC_SEL_VCC_HI  = 4'b0101;
   localparam logic [3:0] SRC_SEL_M0      = 4'b0110;
   localparam logic [3:0] SRC_SEL_EXEC_LO = 4'b0111;
   localparam logic [3:0] SRC_SEL_EXEC_HI = 4'b1000;
   localparam logic [3:0] SRC_SEL_VCCZ    = 4'b1001;
   localparam logic [3:0] SRC_SEL_EXECZ   = 4'b1010;
   localparam logic [3:0] SRC_SEL_SCC     = 4'b1011;

   typedef logic [1:0] collector_state_t;
   localparam collector_state_t ST_IDLE    = 2'd0;
   localparam collector_state_t ST_COLLECT = 2'd1;
   localparam collector_state_t ST_OUT     = 2'd2;

endpackage

// File: rtl/src_operand_collector_scalar_decode.sv
// Maps one slot select plus the captured scalar inputs to a DATA_W word.
// Unknown codes return zero and raise o_illegal; the VGPR code returns zero.
module src_scalar_decode
   import src_operand_collector_pkg::*;
#(
   parameter int SEL_W  = 4,
   parameter int DATA_W = 32
) (
   input  logic [SEL_W-1:0]  i_sel,
   input  logic [9:0]        i_constant,
   input  logic [31:0]       i_literal,
   input  logic [31:0]       i_sgpr,
   input  logic [63:0]       i_vcc,
   input  logic [63:0]       i_exec,
   input  logic [31:0]       i_m0,
   input  logic              i_scc,
   output logic [DATA_W-1:0] o_word,
   output logic              o_illegal
);

   logic [31:0] w_word32;

   always_comb begin
      w_word32  = 32'd0;
      o_illegal = 1'b0;
      case (i_sel)
         SEL_W'(SRC_SEL_LITERAL): w_word32 = i_literal;
         SEL_W'(SRC_SEL_CONST):   w_word32 = 32'd0;
         SEL_W'(SRC_SEL_VGPR):    w_word32 = 32'd0;
         SEL_W'(SRC_SEL_SGPR):    w_word32 = i_sgpr;
         SEL_W'(SRC_SEL_VCC_LO):  w_word32 = i_vcc[31:0];
         SEL_W'(SRC_SEL_VCC_HI):  w_word32 = i_vcc[63:32];
         SEL_W'(SRC_SEL_M0):      w_word32 = i_m0;
         SEL_W'(SRC_SEL_EXEC_LO): w_word32 = i_exec[31:0];
         SEL_W'(SRC_SEL_EXEC_HI): w_word32 = i_exec[63:32];
         SEL_W'(SRC_SEL_VCCZ):    w_word32 = {31'd0, ~&i_vcc};
         SEL_W'(SRC_SEL_EXECZ):   w_word32 = {31'd0, ~&i_exec};
         SEL_W'(SRC_SEL_SCC):     w_word32 = {31'd0, i_scc};
         default:                 o_illegal = 1'b1;
      endcase
      // Only the inline constant is sign-extended; everything else zero-extends.
      if (i_sel == SEL_W'(SRC_SEL_CONST)) o_word = DATA_W'($signed(i_constant));
      else                                o_word = DATA_W'(w_word32);
   end

endmodule

// File: rtl/src_operand_collector.sv
// Collects up to NUM_SRC operands per issue request: scalars captured at accept, VGPR beats later.
// Optional SRC_EXEC_MASK_EN zeroes lanes whose captured exec bit is clear in every slot.
module src_operand_collector
   import src_operand_collector_pkg::*;
#(
   parameter int NUM_SRC   = 3,
   parameter int NUM_LANES = 64,
   parameter int DATA_W    = 32,
   parameter int SEL_W     = 4
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  req_valid,
   output logic                                  req_ready,
   input  logic [NUM_SRC*SEL_W-1:0]              req_sel,
   input  logic [NUM_SRC*10-1:0]                 req_src_constant,
   input  logic [31:0]                           req_literal,
   input  logic [NUM_SRC*32-1:0]                 req_sgpr_data,
   input  logic [63:0]                           req_exec,
   input  logic [63:0]                           req_vcc,
   input  logic [31:0]                           req_m0,
   input  logic                                  req_scc,
   input  logic                                  vgpr_rd_valid,
   input  logic [1:0]                            vgpr_rd_slot,
   input  logic [NUM_LANES*DATA_W-1:0]           vgpr_rd_data,
   output logic                                  out_valid,
   input  logic                                  out_ready,
   output logic [NUM_SRC*NUM_LANES*DATA_W-1:0]   out_data,
   output logic                                  out_err
);

   localparam int SLOT_W = NUM_LANES * DATA_W;

   collector_state_t   r_state, w_state_next;
   logic [NUM_SRC-1:0] r_pending, w_pending_next;
   logic [NUM_SRC-1:0] w_req_vgpr, w_illegal, w_slot_hit;
   logic               r_err, w_err_next;
   logic               w_accept, w_beat_write, w_beat_bad;
   logic [NUM_LANES-1:0] w_mask_req, w_mask_cap;

   assign out_valid    = (r_state == ST_OUT);
   assign req_ready    = (r_state == ST_IDLE) || (out_valid && out_ready);
   assign w_accept     = req_valid && req_ready;
   assign w_beat_write = (r_state == ST_COLLECT) && vgpr_rd_valid && |(w_slot_hit & r_pending);
   assign w_beat_bad   = vgpr_rd_valid && (r_state != ST_IDLE) && !w_beat_write;
   assign out_err      = r_err;

`ifdef SRC_EXEC_MASK_EN
   logic [NUM_LANES-1:0] r_exec;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)          r_exec <= '0;
      else if (w_accept) r_exec <= req_exec[NUM_LANES-1:0];
   end
   assign w_mask_req = req_exec[NUM_LANES-1:0];
   assign w_mask_cap = r_exec;
`else
   assign w_mask_req = '1;
   assign w_mask_cap = '1;
`endif

   for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_slot
      logic [DATA_W-1:0] w_word;
      logic [SLOT_W-1:0] r_slot, w_bcast, w_beat;

      src_scalar_decode #(.SEL_W(SEL_W), .DATA_W(DATA_W)) u_decode (
         .i_sel      (req_sel[gi*SEL_W +: SEL_W]),
         .i_constant (req_src_constant[gi*10 +: 10]),
         .i_literal  (req_literal),
         .i_sgpr     (req_sgpr_data[gi*32 +: 32]),
         .i_vcc      (req_vcc),
         .i_exec     (req_exec),
         .i_m0       (req_m0),
         .i_scc      (req_scc),
         .o_word     (w_word),
         .o_illegal  (w_illegal[gi])
      );

      assign w_req_vgpr[gi] = (req_sel[gi*SEL_W +: SEL_W] == SEL_W'(SRC_SEL_VGPR));
      assign w_slot_hit[gi] = (vgpr_rd_slot == 2'(gi));

      // Exec masking is applied as each slot is written, so the slot is final at OUT entry.
      for (genvar li = 0; li < NUM_LANES; li++) begin : g_lane
         assign w_bcast[li*DATA_W +: DATA_W] = w_mask_req[li] ? w_word : '0;
         assign w_beat[li*DATA_W +: DATA_W]  = w_mask_cap[li] ? vgpr_rd_data[li*DATA_W +: DATA_W] : '0;
      end

      always_ff @(posedge clk or negedge rst) begin
         if (!rst)                              r_slot <= '0;
         else if (w_accept)                     r_slot <= w_req_vgpr[gi] ? '0 : w_bcast;
         else if (w_beat_write && w_slot_hit[gi]) r_slot <= w_beat;
      end

      assign out_data[gi*SLOT_W +: SLOT_W] = r_slot;
   end

   always_comb begin
      w_state_next   = r_state;
      w_pending_next = r_pending;
      w_err_next     = r_err;
      if (w_accept) begin
         w_pending_next = w_req_vgpr;
         w_err_next     = |w_illegal;
         w_state_next   = (|w_req_vgpr) ? ST_COLLECT : ST_OUT;
      end else begin
         if (w_beat_write) begin
            w_pending_next = r_pending & ~w_slot_hit;
            if (w_pending_next == '0) w_state_next = ST_OUT;
         end
         if (w_beat_bad)             w_err_next   = 1'b1;
         if (out_valid && out_ready) w_state_next = ST_IDLE;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= ST_IDLE;
         r_pending <= '0;
         r_err     <= 1'b0;
      end else begin
         r_state   <= w_state_next;
         r_pending <= w_pending_next;
         r_err     <= w_err_next;
      end
   end

endmodule

// File: tb/tb_src_operand_collector.sv
// Directed plus randomized bench for src_operand_collector against a lane-level reference model.
// Honours SRC_EXEC_MASK_EN in its model when the macro is defined.
module tb_src_operand_collector;

   localparam int NS = 3;
   localparam int NL = 64;
   localparam int DW = 32;
   localparam int SW = 4;
   localparam int SLOT_W = NL * DW;
   localparam int PH_IDLE = 0, PH_COLLECT = 1, PH_OUT = 2;

   logic                   clk = 1'b0;
   logic                   rst = 1'b1;
   logic                   req_valid = 1'b0;
   logic                   req_ready;
   logic [NS*SW-1:0]       req_sel = '0;
   logic [NS*10-1:0]       req_src_constant = '0;
   logic [31:0]            req_literal = '0;
   logic [NS*32-1:0]       req_sgpr_data = '0;
   logic [63:0]            req_exec = '0;
   logic [63:0]            req_vcc = '0;
   logic [31:0]            req_m0 = '0;
   logic                   req_scc = 1'b0;
   logic                   vgpr_rd_valid = 1'b0;
   logic [1:0]             vgpr_rd_slot = '0;
   logic [SLOT_W-1:0]      vgpr_rd_data = '0;
   logic                   out_valid;
   logic                   out_ready = 1'b0;
   logic [NS*SLOT_W-1:0]   out_data;
   logic                   out_err;

   always #5 clk = ~clk;

   src_operand_collector #(.NUM_SRC(NS), .NUM_LANES(NL), .DATA_W(DW), .SEL_W(SW)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_sel(req_sel),
      .req_src_constant(req_src_constant), .req_literal(req_literal),
      .req_sgpr_data(req_sgpr_data), .req_exec(req_exec), .req_vcc(req_vcc),
      .req_m0(req_m0), .req_scc(req_scc),
      .vgpr_rd_valid(vgpr_rd_valid), .vgpr_rd_slot(vgpr_rd_slot), .vgpr_rd_data(vgpr_rd_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_err(out_err)
   );

   int checks = 0;
   int failures = 0;

   // Pending request fields and reference-model state
   logic [3:0]        t_sel [NS];
   logic [9:0]        t_const [NS];
   logic [31:0]       t_sgpr [NS];
   logic [31:0]       t_lit, t_m0;
   logic [63:0]       t_exec, t_vcc;
   logic              t_scc;
   logic [SLOT_W-1:0] exp_slot [NS];
   logic [NS-1:0]     exp_pend;
   logic              exp_err;
   logic [63:0]       cap_exec;
   int                mdl_phase;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic chk_slots(input string tag);
      for (int s = 0; s < NS; s++) begin
         int bad_l;
         bad_l = 0;
         checks++;
         assert (out_data[s*SLOT_W +: SLOT_W] === exp_slot[s]) else begin
            failures++;
            for (int l = NL - 1; l >= 0; l--)
               if (out_data[s*SLOT_W + l*DW +: DW] !== exp_slot[s][l*DW +: DW]) bad_l = l;
            $error("FAIL %s slot%0d lane%0d got=%h exp=%h", tag, s, bad_l,
                   out_data[s*SLOT_W + bad_l*DW +: DW], exp_slot[s][bad_l*DW +: DW]);
         end
      end
   endtask

   // Operand value per the select table; bit 32 flags an illegal code
   function automatic logic [32:0] ref_word(input int s);
      logic [31:0] w;
      logic        bad;
      w = 32'd0;
      bad = 1'b0;
      case (int'(t_sel[s]))
         0:  w = t_lit;
         1:  w = t_const[s][9] ? 32'(t_const[s]) - 32'd1024 : 32'(t_const[s]);
         2:  w = 32'd0;
         3:  w = t_sgpr[s];
         4:  w = t_vcc[31:0];
         5:  w = t_vcc[63:32];
         6:  w = t_m0;
         7:  w = t_exec[31:0];
         8:  w = t_exec[63:32];
         9:  w = (t_vcc == 64'hFFFF_FFFF_FFFF_FFFF) ? 32'd0 : 32'd1;
         10: w = (t_exec == 64'hFFFF_FFFF_FFFF_FFFF) ? 32'd0 : 32'd1;
         11: w = t_scc ? 32'd1 : 32'd0;
         default: bad = 1'b1;
      endcase
      return {bad, w};
   endfunction

   function automatic logic [SLOT_W-1:0] masked(input logic [SLOT_W-1:0] d);
`ifdef SRC_EXEC_MASK_EN
      for (int l = 0; l < NL; l++) if (!cap_exec[l]) d[l*DW +: DW] = '0;
`endif
      return d;
   endfunction

   function automatic logic [SLOT_W-1:0] bcast(input logic [31:0] w);
      logic [SLOT_W-1:0] d;
      for (int l = 0; l < NL; l++) d[l*DW +: DW] = w;
      return d;
   endfunction

   function automatic logic [SLOT_W-1:0] rand_slot();
      logic [SLOT_W-1:0] d;
      for (int l = 0; l < NL; l++) d[l*DW +: DW] = $urandom;
      return d;
   endfunction

   task automatic apply_req();
      for (int s = 0; s < NS; s++) begin
         req_sel[s*SW +: SW]           = t_sel[s];
         req_src_constant[s*10 +: 10]  = t_const[s];
         req_sgpr_data[s*32 +: 32]     = t_sgpr[s];
      end
      req_literal = t_lit;
      req_exec    = t_exec;
      req_vcc     = t_vcc;
      req_m0      = t_m0;
      req_scc     = t_scc;
      req_valid   = 1'b1;
   endtask

   task automatic model_accept();
      logic [32:0] r;
      cap_exec = t_exec;
      exp_err  = 1'b0;
      exp_pend = '0;
      for (int s = 0; s < NS; s++) begin
         if (t_sel[s] == 4'd2) begin
            exp_pend[s] = 1'b1;
            exp_slot[s] = '0;
         end else begin
            r = ref_word(s);
            exp_slot[s] = masked(bcast(r[31:0]));
            if (r[32]) exp_err = 1'b1;
         end
      end
      mdl_phase = (exp_pend != '0) ? PH_COLLECT : PH_OUT;
   endtask

   task automatic send_beat(input int sl, input logic [SLOT_W-1:0] d);
      vgpr_rd_valid = 1'b1;
      vgpr_rd_slot  = 2'(sl);
      vgpr_rd_data  = d;
      if (mdl_phase == PH_COLLECT) begin
         if (sl < NS && exp_pend[sl]) begin
            exp_slot[sl] = masked(d);
            exp_pend[sl] = 1'b0;
            if (exp_pend == '0) mdl_phase = PH_OUT;
         end else begin
            exp_err = 1'b1;
         end
      end else if (mdl_phase == PH_OUT) begin
         exp_err = 1'b1;
      end
      tick();
      vgpr_rd_valid = 1'b0;
   endtask

   task automatic rand_req(input bit allow_bad);
      for (int s = 0; s < NS; s++) begin
         int r;
         r = $urandom_range(0, 15);
         if (r < 12)                    t_sel[s] = 4'(r);
         else if (r == 15 && allow_bad) t_sel[s] = 4'($urandom_range(12, 15));
         else                           t_sel[s] = 4'd2;
         t_const[s] = 10'($urandom);
         t_sgpr[s]  = $urandom;
      end
      t_lit  = $urandom;
      t_m0   = $urandom;
      t_scc  = 1'($urandom);
      t_vcc  = ($urandom_range(0, 3) == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : {$urandom, $urandom};
      t_exec = ($urandom_range(0, 2) == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : {$urandom, $urandom};
   endtask

   task automatic drain();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      mdl_phase = PH_IDLE;
   endtask

   initial begin
      mdl_phase = PH_IDLE;
      for (int s = 0; s < NS; s++) exp_slot[s] = '0;
      #1 rst = 1'b0;
      tick();
      tick();
      chk("rst_req_ready", req_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_err", out_err, 0);
      chk("rst_out_data", |out_data, 0);
      rst = 1'b1;
      tick();

      // Scalar-only request
      rand_req(0);
      t_sel[0] = 4'd0; t_sel[1] = 4'd1; t_sel[2] = 4'd3;
      t_lit = 32'hDEADBEEF; t_const[1] = 10'h3FF; t_sgpr[2] = 32'h12;
      t_exec = 64'hFFFF_FFFF_FFFF_FFFF;
      apply_req(); model_accept(); tick(); req_valid = 1'b0;
      chk("scalar_out_valid", out_valid, 1);
      chk("scalar_out_err", out_err, 0);
      chk("scalar_s0_lane0", out_data[0 +: 32], 32'hDEADBEEF);
      chk("scalar_s1_lane63", out_data[SLOT_W + 63*DW +: 32], 32'hFFFFFFFF);
      chk("scalar_s2_lane31", out_data[2*SLOT_W + 31*DW +: 32], 32'h12);
      chk_slots("scalar");
      drain();
      chk("scalar_idle_valid", out_valid, 0);
      chk("scalar_idle_ready", req_ready, 1);

      // Two VGPR slots, out-of-order beats three cycles apart
      rand_req(0);
      t_sel[0] = 4'd2; t_sel[1] = 4'd4; t_sel[2] = 4'd2;
      apply_req(); model_accept(); tick(); req_valid = 1'b0;
      chk("vgpr_collect_valid", out_valid, 0);
      chk("vgpr_collect_ready", req_ready, 0);
      send_beat(2, rand_slot());
      chk("vgpr_after_s2_valid", out_valid, 0);
      tick(); tick();
      chk("vgpr_gap_valid", out_valid, 0);
      send_beat(0, rand_slot());
      chk("vgpr_out_valid", out_valid, 1);
      chk("vgpr_out_err", out_err, 0);
      chk_slots("vgpr");

      // Back-pressure hold, then back-to-back accept
      rand_req(0);
      apply_req();
      for (int c = 0; c < 5; c++) begin
         tick();
         chk("hold_out_valid", out_valid, 1);
         chk("hold_req_ready", req_ready, 0);
         chk("hold_out_err", out_err, 0);
         chk_slots("hold");
      end
      out_ready = 1'b1;
      #1;
      chk("b2b_req_ready", req_ready, 1);
      model_accept();
      tick();
      req_valid = 1'b0; out_ready = 1'b0;
      chk("b2b_out_valid", out_valid, exp_pend == '0);
      while (exp_pend != '0) begin
         int sl;
         do sl = $urandom_range(0, NS - 1); while (!exp_pend[sl]);
         send_beat(sl, rand_slot());
      end
      chk("b2b_final_valid", out_valid, 1);
      chk("b2b_out_err", out_err, exp_err);
      chk_slots("b2b");
      drain();

      // Illegal select plus duplicate beat
      rand_req(0);
      t_sel[0] = 4'd2; t_sel[1] = 4'd13; t_sel[2] = 4'd2;
      apply_req(); model_accept(); tick(); req_valid = 1'b0;
      chk("illegal_err_at_accept", out_err, 1);
      send_beat(0, rand_slot());
      send_beat(0, rand_slot());
      chk("dup_valid", out_valid, 0);
      send_beat(2, rand_slot());
      chk("dup_out_valid", out_valid, 1);
      chk("dup_out_err", out_err, 1);
      chk("illegal_s1_zero", |out_data[SLOT_W +: SLOT_W], 0);
      chk_slots("dup");
      drain();

      // Reset in the middle of collection
      rand_req(0);
      t_sel[0] = 4'd2; t_sel[1] = 4'd0; t_sel[2] = 4'd2;
      apply_req(); model_accept(); tick(); req_valid = 1'b0;
      send_beat(0, rand_slot());
      rst = 1'b0;
      #2;
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_req_ready", req_ready, 1);
      chk("midrst_out_data", |out_data, 0);
      chk("midrst_out_err", out_err, 0);
      mdl_phase = PH_IDLE;
      for (int s = 0; s < NS; s++) exp_slot[s] = '0;
      tick();
      rst = 1'b1;
      tick();
      send_beat(2, rand_slot());
      chk("late_beat_valid", out_valid, 0);
      chk("late_beat_ready", req_ready, 1);
      chk("late_beat_err", out_err, 0);
      chk("late_beat_data", |out_data, 0);

      // Partial exec mask
      rand_req(0);
      t_sel[0] = 4'd0; t_sel[1] = 4'd2; t_sel[2] = 4'd7;
      t_exec = 64'h0000_0000_0000_FFFF;
      apply_req(); model_accept(); tick(); req_valid = 1'b0;
      send_beat(1, rand_slot());
      chk("exec_out_valid", out_valid, 1);
`ifdef SRC_EXEC_MASK_EN
      chk("exec_s0_lane20", out_data[20*DW +: 32], 32'd0);
`else
      chk("exec_s0_lane20", out_data[20*DW +: 32], t_lit);
`endif
      chk("exec_s0_lane3", out_data[3*DW +: 32], t_lit);
      chk_slots("exec");
      drain();

      // Randomized requests
      for (int it = 0; it < 40; it++) begin
         rand_req(1);
         apply_req(); model_accept(); tick(); req_valid = 1'b0;
         chk("rnd_accept_valid", out_valid, exp_pend == '0);
         while (exp_pend != '0) begin
            int sl;
            repeat ($urandom_range(0, 2)) tick();
            if ($urandom_range(0, 5) == 0) begin
               sl = $urandom_range(0, 3);
               if (sl < NS && exp_pend[sl]) sl = 3;
               send_beat(sl, rand_slot());
               chk("rnd_bad_beat_valid", out_valid, 0);
            end
            do sl = $urandom_range(0, NS - 1); while (!exp_pend[sl]);
            send_beat(sl, rand_slot());
            chk("rnd_beat_valid", out_valid, exp_pend == '0);
         end
         chk("rnd_out_err", out_err, exp_err);
         chk_slots("rnd");
         repeat ($urandom_range(0, 3)) begin
            tick();
            chk("rnd_hold_valid", out_valid, 1);
            chk_slots("rnd_hold");
         end
         drain();
         chk("rnd_idle_valid", out_valid, 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
